// File: rtl/vp_frame_ctrl.sv
// Frame controller: measures vs/de geometry per frame, publishes stats and gates the filler enable.
// Latency 1 clk from input edge to every output; no backpressure, it is a pure timing monitor.
module vp_frame_ctrl #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_wr,
    input  logic          cfg_en,
    input  logic          cfg_auto,
    input  logic          pre_vs,
    input  logic          pre_de,
    output logic          fill_en,
    output logic          frame_start,
    output logic          stat_valid,
    output logic [CW-1:0] stat_lines,
    output logic [CW-1:0] stat_max_len,
    output logic [CW-1:0] stat_short,
    output logic [1:0]    stat_err
);

    localparam logic [CW-1:0] H_W     = CW'(H_DISP);
    localparam logic [CW-1:0] V_W     = CW'(V_DISP);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t        state_q, state_d;
    logic          vs_d_q, vs_d_d, de_d_q, de_d_d;
    logic          sh_en_q, sh_en_d, sh_auto_q, sh_auto_d;
    logic [CW-1:0] len_q, len_d, line_q, line_d, short_q, short_d, max_q, max_d;
    logic          long_q, long_d;
    logic          fill_en_q, fill_en_d, frame_start_q, frame_start_d;
    logic          stat_valid_q, stat_valid_d;
    logic [CW-1:0] stat_lines_q, stat_lines_d, stat_max_q, stat_max_d;
    logic [CW-1:0] stat_short_q, stat_short_d;
    logic [1:0]    stat_err_q, stat_err_d;

    logic          vs_rise, de_fall, in_frame, line_end, eff_en, eff_auto, long_n;
    logic [CW-1:0] line_n, short_n, max_n;

    always_comb begin
        vs_rise  = pre_vs & ~vs_d_q;
        de_fall  = de_d_q & ~pre_de;
        in_frame = (state_q == FRAME);
        // A line still open at the boundary is closed into the ending frame.
        line_end = in_frame & (de_fall | (vs_rise & de_d_q));

        line_n  = (line_end && line_q != CNT_MAX) ? line_q + ONE : line_q;
        short_n = (line_end && len_q < H_W && short_q != CNT_MAX) ? short_q + ONE : short_q;
        long_n  = long_q | (line_end && len_q > H_W);
        max_n   = (line_end && len_q > max_q) ? len_q : max_q;

        // A write coincident with the boundary takes effect at that boundary.
        eff_en   = cfg_wr ? cfg_en   : sh_en_q;
        eff_auto = cfg_wr ? cfg_auto : sh_auto_q;

        state_d       = state_q;
        vs_d_d        = pre_vs;
        de_d_d        = pre_de;
        sh_en_d       = eff_en;
        sh_auto_d     = eff_auto;
        len_d         = len_q;
        line_d        = line_q;
        short_d       = short_q;
        max_d         = max_q;
        long_d        = long_q;
        fill_en_d     = fill_en_q;
        frame_start_d = 1'b0;
        stat_valid_d  = 1'b0;
        stat_lines_d  = stat_lines_q;
        stat_max_d    = stat_max_q;
        stat_short_d  = stat_short_q;
        stat_err_d    = stat_err_q;

        if (vs_rise) begin
            state_d       = FRAME;
            frame_start_d = 1'b1;
            len_d         = '0;
            line_d        = '0;
            short_d       = '0;
            max_d         = '0;
            long_d        = 1'b0;
            // On IDLE exit there is no completed frame, so auto mode passes sh_en through.
            fill_en_d     = eff_en & (~eff_auto | ~in_frame | (short_n != '0));
            if (in_frame) begin
                stat_valid_d = 1'b1;
                stat_lines_d = line_n;
                stat_max_d   = max_n;
                stat_short_d = short_n;
                stat_err_d   = {line_n != V_W, long_n};
            end
        end else if (in_frame) begin
            if (pre_de)
                len_d = (len_q != CNT_MAX) ? len_q + ONE : len_q;
            else if (de_fall)
                len_d = '0;
            line_d  = line_n;
            short_d = short_n;
            max_d   = max_n;
            long_d  = long_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            vs_d_q        <= 1'b0;
            de_d_q        <= 1'b0;
            sh_en_q       <= 1'b0;
            sh_auto_q     <= 1'b0;
            len_q         <= '0;
            line_q        <= '0;
            short_q       <= '0;
            max_q         <= '0;
            long_q        <= 1'b0;
            fill_en_q     <= 1'b0;
            frame_start_q <= 1'b0;
            stat_valid_q  <= 1'b0;
            stat_lines_q  <= '0;
            stat_max_q    <= '0;
            stat_short_q  <= '0;
            stat_err_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            vs_d_q        <= vs_d_d;
            de_d_q        <= de_d_d;
            sh_en_q       <= sh_en_d;
            sh_auto_q     <= sh_auto_d;
            len_q         <= len_d;
            line_q        <= line_d;
            short_q       <= short_d;
            max_q         <= max_d;
            long_q        <= long_d;
            fill_en_q     <= fill_en_d;
            frame_start_q <= frame_start_d;
            stat_valid_q  <= stat_valid_d;
            stat_lines_q  <= stat_lines_d;
            stat_max_q    <= stat_max_d;
            stat_short_q  <= stat_short_d;
            stat_err_q    <= stat_err_d;
        end
    end

    assign fill_en      = fill_en_q;
    assign frame_start  = frame_start_q;
    assign stat_valid   = stat_valid_q;
    assign stat_lines   = stat_lines_q;
    assign stat_max_len = stat_max_q;
    assign stat_short   = stat_short_q;
    assign stat_err     = stat_err_q;

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// Directed bench for vp_frame_ctrl with a small geometry (8 pixels x 4 lines).
module tb_vp_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst, cfg_wr, cfg_en, cfg_auto, pre_vs, pre_de;
    logic        fill_en, frame_start, stat_valid;
    logic [11:0] stat_lines, stat_max_len, stat_short;
    logic [1:0]  stat_err;
    logic [40:0] obs;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    vp_frame_ctrl #(.H_DISP(8), .V_DISP(4), .CW(12)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_en(cfg_en), .cfg_auto(cfg_auto),
        .pre_vs(pre_vs), .pre_de(pre_de), .fill_en(fill_en), .frame_start(frame_start),
        .stat_valid(stat_valid), .stat_lines(stat_lines), .stat_max_len(stat_max_len),
        .stat_short(stat_short), .stat_err(stat_err)
    );

    always #5 clk = ~clk;

    // {fill_en, frame_start, stat_valid, stat_err, stat_lines, stat_max_len, stat_short}
    assign obs = {fill_en, frame_start, stat_valid, stat_err, stat_lines, stat_max_len, stat_short};

    task automatic cyc(input logic vs, input logic de);
        pre_vs = vs;
        pre_de = de;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic wr_cfg(input logic en, input logic au);
        cfg_wr = 1'b1; cfg_en = en; cfg_auto = au;
        cyc(1'b0, 1'b0);
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk_cnt++;
        if (obs !== 41'd0) $display("FAIL reset_outputs got %h exp %h", obs, 41'd0);
        else pass_cnt++;
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'b00, 12'd0, 12'd0, 12'd0})
            $display("FAIL reset_first_vs got %h exp %h", obs, {1'b0, 1'b1, 1'b0, 2'b00, 36'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
        chk_cnt++;
        if (obs !== 41'd0) $display("FAIL reset_after_vs got %h exp %h", obs, 41'd0);
        else pass_cnt++;
    endtask

    task automatic test_manual_en;
        wr_cfg(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk_cnt++;
        if (fill_en !== 1'b0) $display("FAIL manual_en_midframe got %b exp 0", fill_en);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) line(8);
        chk_cnt++;
        if (fill_en !== 1'b0) $display("FAIL manual_en_before_vs got %b exp 0", fill_en);
        else pass_cnt++;
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0})
            $display("FAIL clean_frame got %h exp %h", obs, {1'b1, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
        chk_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 2'b00, 12'd4, 12'd8, 12'd0})
            $display("FAIL stat_hold got %h exp %h", obs, {1'b1, 1'b0, 1'b0, 2'b00, 12'd4, 12'd8, 12'd0});
        else pass_cnt++;
    endtask

    task automatic test_manual_dis;
        wr_cfg(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) line(8);
        chk_cnt++;
        if (fill_en !== 1'b1) $display("FAIL manual_dis_midframe got %b exp 1", fill_en);
        else pass_cnt++;
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0})
            $display("FAIL manual_dis_vs got %h exp %h", obs, {1'b0, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_auto;
        wr_cfg(1'b1, 1'b1);
        line(8); line(5); line(8); line(6);
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd2})
            $display("FAIL auto_short got %h exp %h", obs, {1'b1, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd2});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) line(8);
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0})
            $display("FAIL auto_clean got %h exp %h", obs, {1'b0, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_error;
        line(8); line(10); line(8);
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b11, 12'd3, 12'd10, 12'd0})
            $display("FAIL error_frame got %h exp %h", obs, {1'b0, 1'b1, 1'b1, 2'b11, 12'd3, 12'd10, 12'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_cfg_at_vs;
        line(8); line(8);
        cfg_wr = 1'b1; cfg_en = 1'b1; cfg_auto = 1'b0;
        cyc(1'b1, 1'b0);
        cfg_wr = 1'b0;
        chk_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 2'b10, 12'd2, 12'd8, 12'd0})
            $display("FAIL cfg_at_vs got %h exp %h", obs, {1'b1, 1'b1, 1'b1, 2'b10, 12'd2, 12'd8, 12'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_de_fall_at_vs;
        line(8); line(8); line(8);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd1})
            $display("FAIL de_fall_at_vs got %h exp %h", obs, {1'b1, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd1});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_mid_reset;
        line(8); line(5);
        rst = 1'b1;
        cyc(1'b0, 1'b1);
        rst = 1'b0;
        chk_cnt++;
        if (obs !== 41'd0) $display("FAIL mid_reset got %h exp %h", obs, 41'd0);
        else pass_cnt++;
        cyc(1'b0, 1'b0);
        line(3);
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b0, 2'b00, 12'd0, 12'd0, 12'd0})
            $display("FAIL mid_reset_vs got %h exp %h", obs, {1'b0, 1'b1, 1'b0, 2'b00, 36'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) line(8);
        cyc(1'b1, 1'b0);
        chk_cnt++;
        if (obs !== {1'b0, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0})
            $display("FAIL post_reset_frame got %h exp %h", obs, {1'b0, 1'b1, 1'b1, 2'b00, 12'd4, 12'd8, 12'd0});
        else pass_cnt++;
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_en = 1'b0; cfg_auto = 1'b0;
        pre_vs = 1'b0; pre_de = 1'b0;
        test_reset;
        test_manual_en;
        test_manual_dis;
        test_auto;
        test_error;
        test_cfg_at_vs;
        test_de_fall_at_vs;
        test_mid_reset;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
